// File: rtl/bram_fifo_ctrl.sv
// FIFO controller wrapping an external 1W/1R block RAM with a 1-cycle registered read.
// Owns the wrap-bit pointers, registered status/occupancy and one-cycle error pulses.
module bram_fifo_ctrl #(
   parameter int BLOCKSIZE = 10,
   parameter int AF_LEVEL  = 2040
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [31:0]          wr_data,
   input  logic                 rd_en,
   output logic [31:0]          rd_data,
   output logic                 rd_valid,
   output logic                 full,
   output logic                 empty,
   output logic                 almost_full,
   output logic [BLOCKSIZE+1:0] count,
   output logic                 overflow,
   output logic                 underflow,
   output logic [BLOCKSIZE:0]   w1_addr,
   output logic [31:0]          w1_din,
   output logic                 en_w1,
   output logic [BLOCKSIZE:0]   r1_addr,
   input  logic [31:0]          d1
);

   localparam int ADDR_W = BLOCKSIZE + 1;
   localparam int PTR_W  = ADDR_W + 1;
   localparam logic [PTR_W-1:0] DEPTH_P = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [PTR_W-1:0] AF_P    = PTR_W'(AF_LEVEL);

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic             r_full;
   logic             r_empty;
   logic             r_almost_full;
   logic [PTR_W-1:0] r_count;
   logic             r_rd_valid;
   logic             r_overflow;
   logic             r_underflow;

   logic             w_push_ok;
   logic             w_pop_ok;
   logic [PTR_W-1:0] w_wr_ptr_nxt;
   logic [PTR_W-1:0] w_rd_ptr_nxt;
   logic [PTR_W-1:0] w_count_nxt;

   assign w_push_ok    = wr_en & ~r_full;
   assign w_pop_ok     = rd_en & ~r_empty;
   assign w_wr_ptr_nxt = r_wr_ptr + {{ADDR_W{1'b0}}, w_push_ok};
   assign w_rd_ptr_nxt = r_rd_ptr + {{ADDR_W{1'b0}}, w_pop_ok};
   // Modulo subtraction; the wrap bit separates full (DEPTH) from empty (0).
   assign w_count_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;

   // Write strobe is gated by reset so nothing lands in the RAM while held in reset.
   assign en_w1   = w_push_ok & ~rst;
   assign w1_addr = r_wr_ptr[ADDR_W-1:0];
   assign w1_din  = wr_data;
   assign r1_addr = r_rd_ptr[ADDR_W-1:0];
   assign rd_data = d1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_full        <= 1'b0;
         r_empty       <= 1'b1;
         r_almost_full <= 1'b0;
         r_count       <= '0;
         r_rd_valid    <= 1'b0;
         r_overflow    <= 1'b0;
         r_underflow   <= 1'b0;
      end else begin
         r_wr_ptr      <= w_wr_ptr_nxt;
         r_rd_ptr      <= w_rd_ptr_nxt;
         r_full        <= (w_count_nxt == DEPTH_P);
         r_empty       <= (w_count_nxt == '0);
         r_almost_full <= (w_count_nxt >= AF_P);
         r_count       <= w_count_nxt;
         r_rd_valid    <= w_pop_ok;
         r_overflow    <= wr_en & r_full;
         r_underflow   <= rd_en & r_empty;
      end
   end

   assign full        = r_full;
   assign empty       = r_empty;
   assign almost_full = r_almost_full;
   assign count       = r_count;
   assign rd_valid    = r_rd_valid;
   assign overflow    = r_overflow;
   assign underflow   = r_underflow;

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Bench for bram_fifo_ctrl: RAM model with registered read, queue-based reference model,
// directed boundary steps followed by randomized push/pop traffic.
module tb_bram_fifo_ctrl;

   localparam int BLOCKSIZE = 10;
   localparam int AF_LEVEL  = 2040;
   localparam int DEPTH     = 2048;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [31:0] wr_data;
   logic        rd_en;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        full;
   logic        empty;
   logic        almost_full;
   logic [11:0] count;
   logic        overflow;
   logic        underflow;
   logic [10:0] w1_addr;
   logic [31:0] w1_din;
   logic        en_w1;
   logic [10:0] r1_addr;
   logic [31:0] d1;

   logic [31:0] mem [0:DEPTH-1];
   logic [31:0] exp_q[$];
   int          wr_idx;
   int          total = 0;
   int          bad   = 0;

   bram_fifo_ctrl #(.BLOCKSIZE(BLOCKSIZE), .AF_LEVEL(AF_LEVEL)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
      .almost_full(almost_full), .count(count), .overflow(overflow),
      .underflow(underflow), .w1_addr(w1_addr), .w1_din(w1_din), .en_w1(en_w1),
      .r1_addr(r1_addr), .d1(d1)
   );

   always #5 clk = ~clk;

   // Block RAM: read-before-write, one-cycle registered read.
   always @(posedge clk) begin
      if (en_w1) mem[w1_addr] <= w1_din;
      d1 <= mem[r1_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_count"}, 32'(count), 32'd0);
      chk({tag, "_empty"}, 32'(empty), 32'd1);
      chk({tag, "_full"}, 32'(full), 32'd0);
      chk({tag, "_af"}, 32'(almost_full), 32'd0);
      chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
      chk({tag, "_ovf"}, 32'(overflow), 32'd0);
      chk({tag, "_unf"}, 32'(underflow), 32'd0);
   endtask

   // One clock cycle of stimulus; the model decides acceptance from its own queue occupancy.
   task automatic step(input logic w, input logic [31:0] wd, input logic r);
      logic        full_m, empty_m, push_m, pop_m;
      logic [31:0] exp_d;
      @(negedge clk);
      wr_en = w; wr_data = wd; rd_en = r;
      full_m  = (exp_q.size() == DEPTH);
      empty_m = (exp_q.size() == 0);
      push_m  = w & !full_m;
      pop_m   = r & !empty_m;
      exp_d   = '0;
      #1;
      chk("en_w1", 32'(en_w1), 32'(push_m));
      if (push_m) begin
         chk("w1_addr", 32'(w1_addr), 32'(wr_idx % DEPTH));
         chk("w1_din", w1_din, wd);
      end
      @(posedge clk);
      if (pop_m) exp_d = exp_q.pop_front();
      if (push_m) begin
         exp_q.push_back(wd);
         wr_idx++;
      end
      #1;
      chk("rd_valid", 32'(rd_valid), 32'(pop_m));
      if (pop_m) chk("rd_data", rd_data, exp_d);
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("full", 32'(full), 32'(exp_q.size() == DEPTH));
      chk("empty", 32'(empty), 32'(exp_q.size() == 0));
      chk("almost_full", 32'(almost_full), 32'(exp_q.size() >= AF_LEVEL));
      chk("overflow", 32'(overflow), 32'(w & full_m));
      chk("underflow", 32'(underflow), 32'(r & empty_m));
   endtask

   initial begin
      int wp, rp;
      wr_idx = 0;
      rst = 1'b1; wr_en = 1'b1; wr_data = 32'hFFFF_FFFF; rd_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_en_w1", 32'(en_w1), 32'd0);
      chk_reset_vals("rst");
      @(negedge clk);
      wr_en = 1'b0;
      rst = 1'b0;

      // Idle, then a refused pop and its one-cycle underflow pulse.
      step(1'b0, 32'h0, 1'b0);
      step(1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b0);

      // Three pushes then three pops back-to-back.
      step(1'b1, 32'h11, 1'b0);
      step(1'b1, 32'h22, 1'b0);
      step(1'b1, 32'h33, 1'b0);
      step(1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b1);

      // Fill to full with index values, then one refused push.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 32'(i), 1'b0);
      chk("fill_full", 32'(full), 32'd1);
      step(1'b1, 32'hDEAD_BEEF, 1'b0);

      // Full with push and pop together: pop wins, push refused.
      step(1'b1, 32'hCAFE_F00D, 1'b1);
      chk("fullrw_count", 32'(count), 32'(DEPTH - 1));
      for (int i = 1; i < DEPTH; i++) step(1'b0, 32'h0, 1'b1);
      chk("drain_empty", 32'(empty), 32'd1);

      // Empty with push and pop together: push wins, pop refused.
      step(1'b1, 32'h5A, 1'b1);
      step(1'b0, 32'h0, 1'b1);

      // Randomized traffic in three phases biased toward filling, balanced, draining.
      for (int ph = 0; ph < 3; ph++) begin
         wp = (ph == 0) ? 75 : (ph == 1) ? 50 : 25;
         rp = 100 - wp;
         for (int c = 0; c < 9000; c++)
            step(1'($urandom_range(99, 0) < wp), 32'($urandom_range(255, 0)),
                 1'($urandom_range(99, 0) < rp));
      end
      while (exp_q.size() > 0) step(1'b0, 32'h0, 1'b1);

      // Fill 100 entries, pop one, then assert reset asynchronously mid-cycle.
      for (int i = 0; i < 100; i++) step(1'b1, 32'(i + 32'h100), 1'b0);
      step(1'b0, 32'h0, 1'b1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("async_en_w1", 32'(en_w1), 32'd0);
      chk_reset_vals("async");
      exp_q.delete();
      wr_idx = 0;
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 32'hAB, 1'b0);
      step(1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
